int_to_fp_converter: RTL and testbench
======================================

// Module: int_to_fp_converter
// PURPOSE
//  Multi-cycle converter from a 64-bit integer (signed or unsigned) to an IEEE-754 double.
//  Inverse of the ALU's FP-to-integer path (OP_FPI).
//  Sits beside the combinational FPU datapath. Its result is returned to the ALU result mux.
//  Normalises iteratively with a leading-zero shift FSM, then rounds round-to-nearest-even.
//  Uses a valid/ready handshake on both the input side and the output side.
// PARAMETERS
//  SHIFT_STEP  4  bits shifted per NORM cycle when the top SHIFT_STEP bits are all zero (1..16)
// PORTS
//  clk          input   1   clock; all state changes on its rising edge
//  rst          input   1   synchronous, active-high reset
//  enable       input   1   0 = FSM and all registers hold their values (power gating)
//  in_valid     input   1   int_operand/is_signed are valid
//  in_ready     output  1   converter can accept; equals (state==IDLE && enable)
//  int_operand  input   64  integer to convert
//  is_signed    input   1   1 = treat int_operand as two's complement
//  out_valid    output  1   fp_result/Inexact are valid
//  out_ready    input   1   consumer accepts the result
//  fp_result    output  64  IEEE-754 double {sign, exp[10:0], mant[51:0]}
//  Inexact      output  1   result was rounded (guard|sticky != 0)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, overrides enable):
//   - state=IDLE; out_valid=0; fp_result=0; Inexact=0; in_ready=1 from the next cycle.
//   - Asserting reset mid-conversion abandons the operation and produces no output.
//  States: IDLE, NORM, ROUND, DONE. With enable=0, no transition and no register update.
//  IDLE:
//   - Transfer on in_valid & in_ready.
//   - sign = is_signed & op[63].
//   - mag = sign ? (~op+1) : op, 64-bit unsigned; -2^63 gives mag=0x8000_0000_0000_0000.
//   - exp = 11'd1086 (1023+63).
//   - If op==0: fp_result=64'h0 (never -0), Inexact=0, go to DONE.
//   - Otherwise go to NORM.
//  NORM, one step per cycle:
//   - mag[63]=1: go to ROUND with no shift.
//   - Else if mag[63:64-SHIFT_STEP]==0: mag<<=SHIFT_STEP, exp-=SHIFT_STEP.
//   - Else: mag<<=1, exp-=1.
//  ROUND:
//   - mant=mag[62:11]; lsb=mag[11]; guard=mag[10]; sticky=|mag[9:0].
//   - up = guard & (sticky | lsb).
//   - If up: mant+=1. If mant was all ones, mant=0 and exp+=1 (max exp 1087; no overflow possible).
//   - Register fp_result={sign,exp,mant} and Inexact=guard|sticky; go to DONE.
//  DONE:
//   - out_valid=1. fp_result and Inexact are held stable until out_ready=1.
//   - On out_valid & out_ready: out_valid=0 at the next edge and state returns to IDLE.
//   - in_ready=0 in every state except IDLE. No new input overlaps a pending result.
//  Latency, counted in edges from the input-transfer edge to out_valid=1:
//   - op==0: 1 edge.
//   - Otherwise: 3+S edges, where S = number of shifting NORM cycles.
//   - Example, SHIFT_STEP=4: mag=1 has 63 leading zeros, so S=15+3=18.
//  fp_result and Inexact retain the last result after the handshake until the next ROUND/zero capture.
// TESTING
//  T1: rst=1 for 2 cycles with random inputs -> out_valid=0, fp_result=0, Inexact=0; in_ready=1 after release.
//  T2: unsigned 1 -> 64'h3FF0_0000_0000_0000, Inexact=0, out_valid exactly 21 edges after transfer (SHIFT_STEP=4).
//      Signed -1 (all ones) -> 64'hBFF0_0000_0000_0000.
//  T3: 64'h8000_0000_0000_0000: signed -> 64'hC3E0_0000_0000_0000; unsigned -> 64'h43E0_0000_0000_0000; latency 3.
//  T4: unsigned 64'hFFFF_FFFF_FFFF_FFFF -> 64'h43F0_0000_0000_0000 (mantissa carry-out), Inexact=1.
//      Unsigned 64'h0020_0000_0000_0001 (tie, even) -> 64'h4340_0000_0000_0000, Inexact=1.
//  T5: op=0 with out_ready=0 held for 5 cycles -> out_valid=1 after 1 edge, fp_result=0 stable, in_ready=0 throughout.
//      Releasing out_ready -> IDLE.
//  T6: enable=0 for 4 cycles mid-NORM, then rst=1 mid-NORM -> state frozen while disabled, no output after reset.
//      Next conversion of 3 -> 64'h4008_0000_0000_0000.

Source files
------------

// File: rtl/int_to_fp_converter_if.sv
// Handshake bundle between a requester and the integer-to-double converter.
// Input side: in_valid/in_ready with operand; output side: out_valid/out_ready with result.
// The converter side uses the slave modport, the requester the master modport.
interface int_to_fp_converter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] int_operand;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_result;
    logic        Inexact;

    modport master (
        output in_valid, int_operand, is_signed, out_ready,
        input  in_ready, out_valid, fp_result, Inexact
    );

    modport slave (
        input  in_valid, int_operand, is_signed, out_ready,
        output in_ready, out_valid, fp_result, Inexact
    );
endinterface

// File: rtl/int_to_fp_converter.sv
// 64-bit signed/unsigned integer to IEEE-754 double, round-to-nearest-even.
// Latency: 1 edge for zero, else 3 + number of shifting normalise cycles.
// One operation in flight; in_ready low until the result is taken by out_ready.
module int_to_fp_converter #(
    parameter int SHIFT_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    int_to_fp_converter_if.slave bus
);
    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  NORM      = 2'd1;
    localparam logic [1:0]  ROUND     = 2'd2;
    localparam logic [1:0]  DONE      = 2'd3;
    // Exponent of a value whose leading one sits in bit 63.
    localparam logic [10:0] EXP_TOP   = 11'd1086;
    localparam logic [10:0] STEP_EXP  = 11'(SHIFT_STEP);

    logic [1:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [63:0] mag_q, mag_d;
    logic [10:0] exp_q, exp_d;
    logic [63:0] fp_result_q, fp_result_d;
    logic        inexact_q, inexact_d;

    logic        op_sign;
    logic [63:0] op_mag;
    logic [51:0] mant_trunc;
    logic        lsb, guard, sticky, round_up;
    logic [52:0] mant_inc;
    logic [10:0] exp_rounded;

    // Operand sign and magnitude; -2^63 negates onto itself, which is the right magnitude.
    always_comb begin
        op_sign = bus.is_signed & bus.int_operand[63];
        op_mag  = op_sign ? (~bus.int_operand + 64'd1) : bus.int_operand;
    end

    // Round-to-nearest-even on the normalised magnitude; bit 63 is the hidden one.
    always_comb begin
        mant_trunc  = mag_q[62:11];
        lsb         = mag_q[11];
        guard       = mag_q[10];
        sticky      = |mag_q[9:0];
        round_up    = guard & (sticky | lsb);
        mant_inc    = {1'b0, mant_trunc} + {52'd0, round_up};
        // A carry out of the mantissa leaves it zero and bumps the exponent.
        exp_rounded = exp_q + {10'd0, mant_inc[52]};
    end

    // Next-state logic for the IDLE/NORM/ROUND/DONE sequence.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        fp_result_d = fp_result_q;
        inexact_d   = inexact_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = op_sign;
                    mag_d  = op_mag;
                    exp_d  = EXP_TOP;
                    if (bus.int_operand == 64'd0) begin
                        fp_result_d = 64'd0;
                        inexact_d   = 1'b0;
                        state_d     = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[63]) begin
                    state_d = ROUND;
                end else if (mag_q[63 -: SHIFT_STEP] == '0) begin
                    mag_d = mag_q << SHIFT_STEP;
                    exp_d = exp_q - STEP_EXP;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 11'd1;
                end
            end
            ROUND: begin
                fp_result_d = {sign_q, exp_rounded, mant_inc[51:0]};
                inexact_d   = guard | sticky;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins over enable, enable low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= 64'd0;
            exp_q       <= 11'd0;
            fp_result_q <= 64'd0;
            inexact_q   <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            fp_result_q <= fp_result_d;
            inexact_q   <= inexact_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && enable;
    assign bus.out_valid = (state_q == DONE);
    assign bus.fp_result = fp_result_q;
    assign bus.Inexact   = inexact_q;
endmodule

// File: tb/tb_int_to_fp_converter.sv
// Randomised and directed bench for int_to_fp_converter with an arithmetic reference model.
// Latency: measured per transaction against the model's leading-zero based prediction.
// Exercises output backpressure, enable freeze and reset mid-conversion.
module tb_int_to_fp_converter;
    localparam int SS = 4;

    logic clk;
    logic rst;
    logic enable;

    int_to_fp_converter_if bus ();

    int_to_fp_converter #(.SHIFT_STEP(SS)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;
    logic [64:0] exp_q[$];   // {inexact, result}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: value-level conversion with explicit round-half-even on the discarded bits.
    task automatic model(input logic [63:0] op, input logic sgn,
                         output logic [63:0] res, output logic inx, output int lat);
        logic        s;
        logic [63:0] mag, norm;
        logic [53:0] keep;
        logic [10:0] rem;
        int          lz, e;
        s   = sgn && op[63];
        mag = s ? (64'd0 - op) : op;
        if (mag == 64'd0) begin
            res = 64'd0; inx = 1'b0; lat = 1;
            return;
        end
        lz = 0;
        while (mag[63 - lz] == 1'b0) lz++;
        norm = mag << lz;
        e    = 1086 - lz;
        keep = {1'b0, norm[63:11]};
        rem  = norm[10:0];
        inx  = (rem != 11'd0);
        if (rem > 11'h400 || (rem == 11'h400 && keep[0])) keep = keep + 54'd1;
        if (keep[53]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        res = {s, e[10:0], keep[51:0]};
        lat = 3 + lz / SS + lz % SS;
    endtask

    // Compare process: every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                check("fp_result", bus.fp_result, exp_q[0][63:0]);
                check("inexact", {63'd0, bus.Inexact}, {63'd0, exp_q[0][64]});
                check("in_ready_while_done", {63'd0, bus.in_ready}, 64'd0);
                if (bus.out_ready && enable) void'(exp_q.pop_front());
            end
        end
    end

    task automatic convert(input logic [63:0] op, input logic sgn, input int rdy_delay,
                           input int gap_at, input int gap_len);
        logic [63:0] er;
        logic        ei;
        int          el, lat, guard_cnt;
        model(op, sgn, er, ei, el);
        if (gap_at >= 0) el = el + gap_len;
        bus.int_operand = op;
        bus.is_signed   = sgn;
        bus.in_valid    = 1'b1;
        guard_cnt = 0;
        while (!bus.in_ready && guard_cnt < 50) begin
            @(posedge clk); #1; guard_cnt++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({ei, er});
        #1;
        bus.in_valid    = 1'b0;
        bus.int_operand = {$urandom(), $urandom()};
        bus.is_signed   = 1'($urandom_range(0, 1));
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            if (lat == gap_at) begin
                enable = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; lat++; end
                enable = 1'b1;
            end else begin
                @(posedge clk); #1; lat++;
            end
        end
        check("latency", 64'(lat), 64'(el));
        if (!bus.out_valid) begin
            exp_q.delete();
            return;
        end
        repeat (rdy_delay) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_take", {63'd0, bus.out_valid}, 64'd0);
        check("result_retained", bus.fp_result, er);
    endtask

    initial begin
        logic [63:0] r, op, mr;
        logic        mi;
        int          ml, cnt;

        // Pin the model with hand-derived doubles.
        model(64'd1, 1'b0, mr, mi, ml);
        check("model_one", mr, 64'h3FF0_0000_0000_0000);
        check("model_one_lat", 64'(ml), 64'd21);
        model(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, mr, mi, ml);
        check("model_neg_one", mr, 64'hBFF0_0000_0000_0000);
        model(64'h8000_0000_0000_0000, 1'b1, mr, mi, ml);
        check("model_min_int", mr, 64'hC3E0_0000_0000_0000);
        check("model_min_lat", 64'(ml), 64'd3);
        model(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, mr, mi, ml);
        check("model_all_ones", mr, 64'h43F0_0000_0000_0000);
        check("model_all_ones_inx", {63'd0, mi}, 64'd1);
        model(64'h0020_0000_0000_0001, 1'b0, mr, mi, ml);
        check("model_tie_even", mr, 64'h4340_0000_0000_0000);
        model(64'd3, 1'b0, mr, mi, ml);
        check("model_three", mr, 64'h4008_0000_0000_0000);

        // T1: reset with junk on the inputs.
        rst = 1'b1; enable = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'(($urandom_range(0, 1)));
        bus.int_operand = {$urandom(), $urandom()}; bus.is_signed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_fp_result", bus.fp_result, 64'd0);
        check("rst_inexact", {63'd0, bus.Inexact}, 64'd0);
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // T2..T4 directed corners, checked against both model and literal result.
        convert(64'd1, 1'b0, 0, -1, 0);
        check("lit_one", bus.fp_result, 64'h3FF0_0000_0000_0000);
        convert(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, -1, 0);
        check("lit_neg_one", bus.fp_result, 64'hBFF0_0000_0000_0000);
        convert(64'h8000_0000_0000_0000, 1'b1, 0, -1, 0);
        check("lit_min_signed", bus.fp_result, 64'hC3E0_0000_0000_0000);
        convert(64'h8000_0000_0000_0000, 1'b0, 0, -1, 0);
        check("lit_min_unsigned", bus.fp_result, 64'h43E0_0000_0000_0000);
        convert(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, -1, 0);
        check("lit_carry_out", bus.fp_result, 64'h43F0_0000_0000_0000);
        check("lit_carry_inx", {63'd0, bus.Inexact}, 64'd1);
        convert(64'h0020_0000_0000_0001, 1'b0, 0, -1, 0);
        check("lit_tie_even", bus.fp_result, 64'h4340_0000_0000_0000);

        // T5: zero with the consumer stalling.
        convert(64'd0, 1'b1, 5, -1, 0);
        check("lit_zero", bus.fp_result, 64'd0);
        check("zero_back_idle", {63'd0, bus.in_ready}, 64'd1);

        // T6: enable gap mid-normalise stretches latency only.
        convert(64'd1, 1'b0, 0, 5, 4);
        check("lit_gap_one", bus.fp_result, 64'h3FF0_0000_0000_0000);

        // T6: reset mid-normalise abandons the conversion.
        bus.int_operand = 64'd1; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) cnt++;
        end
        check("no_output_after_rst", 64'(cnt), 64'd0);
        check("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);
        convert(64'd3, 1'b0, 0, -1, 0);
        check("lit_three", bus.fp_result, 64'h4008_0000_0000_0000);

        // Random sweep over leading-zero counts, signs and backpressure.
        for (int i = 0; i < 300; i++) begin
            r  = {$urandom(), $urandom()};
            op = r >> $urandom_range(0, 63);
            case ($urandom_range(0, 19))
                0:       op = 64'd0;
                1:       op = 64'hFFFF_FFFF_FFFF_FFFF;
                2:       op = 64'h8000_0000_0000_0000;
                3:       op = (r | 64'h400) & ~64'h3FF;
                default: ;
            endcase
            convert(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, 0);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
